// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: per-register pending-write scoreboard, mult/div busy tracking,
// saturating stall counter. Drives pc_write, stall (IF/ID hold), if_flush, id_flush.
//
// Ports:
//   clk, reset (async, active-low)
//   id_* : current ID instruction (valid, sources, dest, load/md/hilo flags)
//   jump_id, branch_taken_ex : control-flow redirects
//   pc_write, stall, if_flush, id_flush, md_busy, stall_count : hazard controls

module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 32,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              id_is_md,
   input  logic              id_reads_hilo,
   input  logic              jump_id,
   input  logic              branch_taken_ex,
   output logic              pc_write,
   output logic              stall,
   output logic              if_flush,
   output logic              id_flush,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [2:0] LD_INIT = 3'(LOAD_LAT);
   localparam logic [5:0] MD_INIT = 6'(MD_LAT);

   logic [2:0]       r_pend [NREG];
   logic [5:0]       r_md;
   logic [CNT_W-1:0] r_cnt;

   logic [NREG-1:0]  w_busy;
   logic             w_rs_hit;
   logic             w_rt_hit;
   logic             w_raw;
   logic             w_md_busy;
   logic             w_md_haz;
   logic             w_hz;
   logic             w_issue;

   always_comb begin
      w_busy = '0;
      for (int i = 1; i < NREG; i++) begin
         w_busy[i] = (r_pend[i] != 3'd0);
      end
   end

   // Register 0 never has a pending write, so r0 sources never hazard.
   assign w_rs_hit  = id_rs_used && (id_rs != '0) && w_busy[id_rs];
   assign w_rt_hit  = id_rt_used && (id_rt != '0) && w_busy[id_rt];
   assign w_raw     = id_valid && (w_rs_hit || w_rt_hit);
   assign w_md_busy = (r_md != 6'd0);
   assign w_md_haz  = id_valid && w_md_busy && (id_is_md || id_reads_hilo);
   assign w_hz      = w_raw || w_md_haz;
   assign w_issue   = id_valid && !w_hz && !branch_taken_ex;

   always_comb begin
      pc_write = 1'b0;
      stall    = 1'b0;
      if_flush = 1'b0;
      id_flush = 1'b0;
      if (reset) begin
         if (branch_taken_ex) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            pc_write = 1'b1;
         end else if (w_hz) begin
            // A jump in ID is dropped here; it is re-presented next cycle.
            stall    = 1'b1;
            id_flush = 1'b1;
         end else if (jump_id) begin
            if_flush = 1'b1;
            pc_write = 1'b1;
         end else begin
            pc_write = 1'b1;
         end
      end
   end

   assign md_busy     = w_md_busy;
   assign stall_count = r_cnt;

   // Issue reload wins over the per-cycle decrement for the same register.
   // Non-load writers clear the entry since forwarding covers ALU results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_pend[i] <= 3'd0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (i == 0) begin
               r_pend[i] <= 3'd0;
            end else if (w_issue && id_wr_en && (id_rd == REG_AW'(i))) begin
               r_pend[i] <= id_is_load ? LD_INIT : 3'd0;
            end else if (r_pend[i] != 3'd0) begin
               r_pend[i] <= r_pend[i] - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_md <= 6'd0;
      end else if (w_issue && id_is_md) begin
         r_md <= MD_INIT;
      end else if (w_md_busy) begin
         r_md <= r_md - 6'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (stall && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table with expected-result queue,
// plus hand sequences for mid-stall reset and stall counter saturation.

module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_rs_used;
   logic       id_rt_used;
   logic       id_wr_en;
   logic [4:0] id_rd;
   logic       id_is_load;
   logic       id_is_md;
   logic       id_reads_hilo;
   logic       jump_id;
   logic       branch_taken_ex;

   logic        a_pc, a_st, a_iff, a_idf, a_mdb;
   logic [3:0]  a_cnt;
   logic        b_pc, b_st, b_iff, b_idf, b_mdb;
   logic [15:0] b_cnt;

   int n_pass;
   int n_tot;

   hazard_scoreboard #(
      .NREG(32), .REG_AW(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(4)
   ) ua (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
      .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
      .jump_id(jump_id), .branch_taken_ex(branch_taken_ex),
      .pc_write(a_pc), .stall(a_st), .if_flush(a_iff), .id_flush(a_idf),
      .md_busy(a_mdb), .stall_count(a_cnt)
   );

   hazard_scoreboard #(
      .NREG(32), .REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(16)
   ) ub (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
      .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
      .jump_id(jump_id), .branch_taken_ex(branch_taken_ex),
      .pc_write(b_pc), .stall(b_st), .if_flush(b_iff), .id_flush(b_idf),
      .md_busy(b_mdb), .stall_count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // o = {pc_write, stall, if_flush, id_flush, md_busy}
   typedef struct {
      logic       rst;
      logic       inst;
      logic       v;
      logic [4:0] rs;
      logic       rsu;
      logic [4:0] rt;
      logic       rtu;
      logic       we;
      logic [4:0] rd;
      logic       ld;
      logic       md;
      logic       hl;
      logic       jp;
      logic       br;
      logic [4:0] o;
      int         c;
   } vec_t;

   typedef struct {
      int         idx;
      logic       inst;
      logic [4:0] o;
      int         c;
   } exp_t;

   vec_t tbl[$];
   exp_t eq[$];

   function automatic vec_t mk(
      input int r, input int n, input int v,
      input int rs, input int rsu, input int rt, input int rtu,
      input int we, input int rd, input int ld, input int md,
      input int hl, input int jp, input int br,
      input logic [4:0] o, input int c
   );
      vec_t t;
      t.rst = 1'(r);   t.inst = 1'(n); t.v = 1'(v);
      t.rs = 5'(rs);   t.rsu = 1'(rsu);
      t.rt = 5'(rt);   t.rtu = 1'(rtu);
      t.we = 1'(we);   t.rd = 5'(rd);  t.ld = 1'(ld);
      t.md = 1'(md);   t.hl = 1'(hl);
      t.jp = 1'(jp);   t.br = 1'(br);
      t.o = o;         t.c = c;
      return t;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      n_tot++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, got, want);
   endtask

   task automatic idle_in();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_wr_en = 0; id_rd = 0; id_is_load = 0; id_is_md = 0;
      id_reads_hilo = 0; jump_id = 0; branch_taken_ex = 0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v; id_rs = t.rs; id_rt = t.rt;
      id_rs_used = t.rsu; id_rt_used = t.rtu;
      id_wr_en = t.we; id_rd = t.rd; id_is_load = t.ld;
      id_is_md = t.md; id_reads_hilo = t.hl;
      jump_id = t.jp; branch_taken_ex = t.br;
   endtask

   initial begin
      exp_t e;
      logic [4:0] go;
      int gc;

      n_pass = 0;
      n_tot  = 0;
      idle_in();
      reset = 1'b0;

      // Segment 1, LOAD_LAT=1 / MD_LAT=4 instance
      tbl.push_back(mk(1,0,1, 0,0,0,0, 1,5,1,0,0,0,0, 5'b10000,0));
      tbl.push_back(mk(0,0,1, 5,1,0,0, 1,6,0,0,0,0,0, 5'b01010,0));
      tbl.push_back(mk(0,0,1, 5,1,0,0, 1,6,0,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,0,1,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 0,1,0,1, 1,1,0,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,8,1,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 8,0,3,1, 1,9,0,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0,0,1,0, 5'b10100,1));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,10,1,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,0,1, 0,0,10,1, 1,13,0,0,0,1,0, 5'b01010,1));
      tbl.push_back(mk(0,0,1, 0,0,10,1, 1,13,0,0,0,1,0, 5'b10100,2));
      tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 5'b10000,2));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,5,1,0,0,0,0, 5'b10000,2));
      tbl.push_back(mk(0,0,1, 5,1,0,0, 1,11,1,0,0,0,1, 5'b10110,2));
      tbl.push_back(mk(0,0,1, 11,1,5,1, 0,0,0,0,0,0,0, 5'b10000,2));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,1,0,0,0, 5'b10000,2));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0,0,0,0, 5'b10001,2));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,12,0,0,1,0,0, 5'b01011,2));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,12,0,0,1,0,0, 5'b01011,3));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,12,0,0,1,0,0, 5'b01011,4));
      tbl.push_back(mk(0,0,1, 0,0,0,0, 1,12,0,0,1,0,0, 5'b10000,5));
      tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 5'b10000,5));
      // Segment 2, LOAD_LAT=3 instance
      tbl.push_back(mk(1,1,1, 0,0,0,0, 1,7,1,0,0,0,0, 5'b10000,0));
      tbl.push_back(mk(0,1,1, 1,1,0,0, 1,2,0,0,0,0,0, 5'b10000,0));
      tbl.push_back(mk(0,1,1, 3,1,0,0, 1,4,0,0,0,0,0, 5'b10000,0));
      tbl.push_back(mk(0,1,1, 0,0,7,1, 1,8,0,0,0,0,0, 5'b01010,0));
      tbl.push_back(mk(0,1,1, 0,0,7,1, 1,8,0,0,0,0,0, 5'b10000,1));
      tbl.push_back(mk(0,1,0, 0,0,0,0, 0,0,0,0,0,0,0, 5'b10000,1));

      // Reset state
      #2;
      chk("rst_a_outs", int'({a_pc,a_st,a_iff,a_idf,a_mdb}), 0);
      chk("rst_a_cnt", int'(a_cnt), 0);
      chk("rst_b_outs", int'({b_pc,b_st,b_iff,b_idf,b_mdb}), 0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         drive(tbl[i]);
         e.idx = i; e.inst = tbl[i].inst; e.o = tbl[i].o; e.c = tbl[i].c;
         eq.push_back(e);
         @(negedge clk);
         e = eq.pop_front();
         go = e.inst ? {b_pc,b_st,b_iff,b_idf,b_mdb}
                     : {a_pc,a_st,a_iff,a_idf,a_mdb};
         gc = e.inst ? int'(b_cnt) : int'(a_cnt);
         n_tot++;
         if (go == e.o) n_pass++;
         else $display("FAIL vec%0d outs: got %b want %b", e.idx, go, e.o);
         n_tot++;
         if (gc == e.c) n_pass++;
         else $display("FAIL vec%0d cnt: got %0d want %0d", e.idx, gc, e.c);
         @(posedge clk);
         #1;
      end

      // Reset asserted mid-stall while pend[5]=2 (LOAD_LAT=3 instance)
      do_reset();
      drive(mk(0,1,1, 0,0,0,0, 1,5,1,0,0,0,0, 5'b0,0));
      @(posedge clk); #1;
      drive(mk(0,1,1, 0,0,0,0, 0,0,0,0,0,0,0, 5'b0,0));
      @(posedge clk); #1;
      drive(mk(0,1,1, 5,1,0,0, 1,6,0,0,0,0,0, 5'b0,0));
      @(negedge clk);
      chk("pre_rst_stall", int'({b_pc,b_st,b_idf}), 3'b011);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_b_outs", int'({b_pc,b_st,b_iff,b_idf,b_mdb}), 0);
      chk("mid_rst_b_cnt", int'(b_cnt), 0);
      chk("mid_rst_a_outs", int'({a_pc,a_st,a_iff,a_idf,a_mdb}), 0);
      #1 reset = 1'b1;
      #1;
      chk("post_rst_r5", int'({b_pc,b_st,b_idf}), 3'b100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_cnt", int'(b_cnt), 0);

      // Back-to-back mult/div stalls drive the 4-bit counter into saturation
      @(posedge clk); #1;
      do_reset();
      drive(mk(0,0,1, 0,0,0,0, 0,0,0,1,0,0,0, 5'b0,0));
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 10) chk("sat_mid_cnt", int'(a_cnt), 8);
         if (i == 3 || i == 5) chk($sformatf("sat_stall%0d", i), int'(a_st), (i % 5 != 0) ? 1 : 0);
         @(posedge clk); #1;
      end
      chk("sat_final_cnt", int'(a_cnt), 15);
      @(posedge clk); #1;
      chk("sat_hold_cnt", int'(a_cnt), 15);

      idle_in();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
